// File: rtl/decoder_pkg.sv
// Shared constants and the decode table for the 2-to-4 decoder.
//   SEL_W      : width of the binary select code
//   OUT_W      : width of the decoded output
//   dec_onehot : active-high one-hot pattern for a select code
//   idle_pat   : output pattern that asserts no line, for either polarity
package decoder_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 4;

  function automatic logic [OUT_W-1:0] dec_onehot(input logic [SEL_W-1:0] code);
    logic [OUT_W-1:0] pat;
    pat = '0;
    pat[code] = 1'b1;
    return pat;
  endfunction

  function automatic logic [OUT_W-1:0] idle_pat(input logic active_low);
    return active_low ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  endfunction

endpackage

// File: rtl/decoder_2x4_core.sv
// Purely combinational 2-to-4 decode with output polarity select.
//   i : binary select code
//   d : one-hot decode of i (one-cold when ACTIVE_LOW=1); an i with
//       unknown bits falls to the default branch and yields no active line
module decoder_2x4_core
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [SEL_W-1:0] i,
  output logic [OUT_W-1:0] d
);

  logic [OUT_W-1:0] hot;

  always_comb begin
    hot = '0;
    // Explicit items so an X/Z code misses every item and lands in default.
    case (i)
      2'b00, 2'b01, 2'b10, 2'b11: hot = dec_onehot(i);
      default:                    hot = '0;
    endcase
    d = ACTIVE_LOW ? ~hot : hot;
  end

endmodule

// File: rtl/decoder_2x4.sv
// Registered 2-to-4 decoder, one cycle latency.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, wins over en
//   en    : decode enable
//   i     : binary select code
//   d     : registered decode (idle pattern when disabled, unless holding)
//   valid : 1 when d holds a decode of an i sampled with en=1
module decoder_2x4
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter bit HOLD_ON_DISABLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] i,
  output logic [OUT_W-1:0] d,
  output logic             valid
);

  localparam logic [OUT_W-1:0] IDLE = idle_pat(ACTIVE_LOW);

  logic [OUT_W-1:0] dec;
  logic [OUT_W-1:0] d_d, d_q;
  logic             valid_d, valid_q;

  decoder_2x4_core #(.ACTIVE_LOW(ACTIVE_LOW)) u_core (
    .i (i),
    .d (dec)
  );

  always_comb begin
    d_d     = HOLD_ON_DISABLE ? d_q : IDLE;
    valid_d = 1'b0;
    if (en) begin
      d_d     = dec;
      valid_d = 1'b1;
    end
    if (rst) begin
      d_d     = IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    d_q     <= d_d;
    valid_q <= valid_d;
  end

  assign d     = d_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_decoder_2x4.sv
// Directed bench for decoder_2x4: three instances (default, hold-on-disable,
// active-low) share one stimulus stream; expected values are hand-written.
module tb_decoder_2x4;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] i;
  logic [3:0] d_base, d_hold, d_al;
  logic       v_base, v_hold, v_al;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_2x4 #(.ACTIVE_LOW(1'b0), .HOLD_ON_DISABLE(1'b0)) u_base (
    .clk(clk), .rst(rst), .en(en), .i(i), .d(d_base), .valid(v_base));
  decoder_2x4 #(.ACTIVE_LOW(1'b0), .HOLD_ON_DISABLE(1'b1)) u_hold (
    .clk(clk), .rst(rst), .en(en), .i(i), .d(d_hold), .valid(v_hold));
  decoder_2x4 #(.ACTIVE_LOW(1'b1), .HOLD_ON_DISABLE(1'b0)) u_al (
    .clk(clk), .rst(rst), .en(en), .i(i), .d(d_al), .valid(v_al));

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // At most one active line per instance, every checked cycle.
  task automatic chk_onehot(input string tag);
    chk({tag, "/onehot_base"}, {3'b0, $countones(d_base) <= 1}, 4'b0001);
    chk({tag, "/onehot_hold"}, {3'b0, $countones(d_hold) <= 1}, 4'b0001);
    chk({tag, "/onehot_al"},   {3'b0, $countones(~d_al)  <= 1}, 4'b0001);
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] si,
                      input logic [3:0] eb, input logic [3:0] eh, input logic [3:0] ea,
                      input logic ev);
    rst = r; en = e; i = si;
    @(posedge clk); #1;
    chk({tag, "/d_base"}, d_base, eb);
    chk({tag, "/d_hold"}, d_hold, eh);
    chk({tag, "/d_al"},   d_al,   ea);
    chk({tag, "/v_base"}, {3'b0, v_base}, {3'b0, ev});
    chk({tag, "/v_hold"}, {3'b0, v_hold}, {3'b0, ev});
    chk({tag, "/v_al"},   {3'b0, v_al},   {3'b0, ev});
    chk_onehot(tag);
  endtask

  initial begin
    logic [3:0] ex_hi, ex_lo;
    rst = 1'b1; en = 1'b1; i = 2'b11;
    //   tag        rst  en   i      base     hold     al       valid
    step("rst0",    1'b1, 1'b1, 2'b11, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    step("rst1",    1'b1, 1'b0, 2'b01, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    step("sw00",    1'b0, 1'b1, 2'b00, 4'b0001, 4'b0001, 4'b1110, 1'b1);
    step("sw01",    1'b0, 1'b1, 2'b01, 4'b0010, 4'b0010, 4'b1101, 1'b1);
    step("sw10",    1'b0, 1'b1, 2'b10, 4'b0100, 4'b0100, 4'b1011, 1'b1);
    step("sw11",    1'b0, 1'b1, 2'b11, 4'b1000, 4'b1000, 4'b0111, 1'b1);
    step("rep10",   1'b0, 1'b1, 2'b10, 4'b0100, 4'b0100, 4'b1011, 1'b1);
    step("same10",  1'b0, 1'b1, 2'b10, 4'b0100, 4'b0100, 4'b1011, 1'b1);
    step("dis_pre", 1'b0, 1'b1, 2'b01, 4'b0010, 4'b0010, 4'b1101, 1'b1);
    step("dis0",    1'b0, 1'b0, 2'b11, 4'b0000, 4'b0010, 4'b1111, 1'b0);
    step("dis1",    1'b0, 1'b0, 2'b00, 4'b0000, 4'b0010, 4'b1111, 1'b0);
    step("mid_pre", 1'b0, 1'b1, 2'b10, 4'b0100, 4'b0100, 4'b1011, 1'b1);
    step("mid_rst", 1'b1, 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    step("mid_res", 1'b0, 1'b1, 2'b10, 4'b0100, 4'b0100, 4'b1011, 1'b1);
    step("hold_a",  1'b0, 1'b1, 2'b11, 4'b1000, 4'b1000, 4'b0111, 1'b1);
    step("hold_b",  1'b0, 1'b0, 2'b00, 4'b0000, 4'b1000, 4'b1111, 1'b0);
    step("hold_rst",1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b1111, 1'b0);

    // Unknown select bits decode to idle on a four-state simulator; a
    // two-state simulator resolves them, so the expectation follows what
    // the bench actually drove.
    rst = 1'b0; en = 1'b1; i = 2'bx1;
    if ($isunknown(i)) ex_hi = 4'b0000;
    else               ex_hi = 4'b0001 << i;
    ex_lo = ~ex_hi;
    @(posedge clk); #1;
    chk("xin/d_base", d_base, ex_hi);
    chk("xin/d_hold", d_hold, ex_hi);
    chk("xin/d_al",   d_al,   ex_lo);
    chk("xin/v_base", {3'b0, v_base}, 4'b0001);
    chk("xin/v_al",   {3'b0, v_al},   4'b0001);
    chk_onehot("xin");

    step("post_x",  1'b0, 1'b1, 2'b00, 4'b0001, 4'b0001, 4'b1110, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
